cla_mp_arbiter: RTL and testbench
=================================

// Module: cla_mp_arbiter
// PURPOSE
//  Shares one 8-bit carry-lookahead adder between NUM_REQ requesters using round-robin arbitration.
//  Runs each granted add/sub over WORDS bytes, LSB first, one byte per cycle, chaining the carry.
//  Returns a registered WORDS*8-bit result with carry, signed overflow and requester id.
//  Sits between client datapaths and the CarryLookAhead instance it owns.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WORDS    4  bytes per operand; operand width OW = 8*WORDS
//  IDW      $clog2(NUM_REQ)  id width (localparam)
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            asynchronous, active-high; clears all state
//  req_valid  in   NUM_REQ      request pending, one bit per requester
//  req_mode   in   NUM_REQ      0 = x+y, 1 = x-y
//  req_x      in   NUM_REQ*OW   operand x, requester i at [i*OW +: OW]
//  req_y      in   NUM_REQ*OW   operand y, same packing
//  req_ready  out  NUM_REQ      one-hot accept strobe
//  rsp_valid  out  1            result available
//  rsp_ready  in   1            consumer accepts result
//  rsp_id     out  IDW          requester that owns the result
//  rsp_sum    out  OW           result
//  rsp_cout   out  1            final carry (sub: 1 = no borrow)
//  rsp_ovf    out  1            two's-complement signed overflow
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
//    Reset values: FSM=IDLE, rr pointer=0 (requester 0 highest priority).
//  FSM states:
//  - IDLE: if any req_valid, pick the first set bit searching from ptr upward with wrap.
//    Drive req_ready[g]=1 combinationally for that cycle only.
//    On the clock edge, latch x, y^{OW{mode}}, mode and g; set carry=mode; byte idx=0; ->RUN.
//  - RUN: drive the adder with the latched x byte, the conditioned y byte and cin=carry.
//    Tie the adder mode port to 0; the controller performs the inversion itself.
//    Each cycle, store the sum byte into result[idx], carry<=cout, idx++.
//    After byte WORDS-1, go to RESP. RUN lasts exactly WORDS cycles.
//  - RESP: rsp_valid=1. rsp_sum, rsp_cout, rsp_ovf and rsp_id are held stable until rsp_ready.
//    When rsp_valid&&rsp_ready: ptr<=(g+1) mod NUM_REQ, then go to IDLE.
//  Latency: the accept edge is cycle 0; rsp_valid is first high at cycle WORDS+1.
//    Minimum spacing between accepts is WORDS+2 cycles.
//  req_ready is never asserted outside IDLE, and at most one bit is ever set.
//  Requester contract: x, y and mode stay stable while valid until ready.
//    A requester may drop valid before it is granted; this causes no side effects.
//  rsp_ovf = (x[OW-1] == yc[OW-1]) && (sum[OW-1] != x[OW-1]).
//    yc is the conditioned y; the overflow bit is registered with the last byte.
//  Mode=1 with y=0 gives sum=x and cout=1.
//  An asynchronous reset in any state aborts the operation and restores reset values.
//    No response is issued for the aborted request.
//  Width rule: all arithmetic is modulo 2^OW; the carry out of the top byte appears only on rsp_cout.
// STRUCTURE
//  Shared package cla_pkg: FSM state enum {IDLE,RUN,RESP}; localparam BYTE_W=8.
//  Sub-module: one instance of the existing CarryLookAhead (x,y,mode,cin,sum,cout).
//  The round-robin pick is a function in this file; no further sub-modules.
// TESTING (NUM_REQ=4, WORDS=4)
//  1. req0 add x=0x0000007F y=0x00000001
//     -> sum=0x00000080, cout=0, ovf=0, id=0, rsp_valid at cycle 5.
//  2. add x=0xFFFFFFFF y=0x00000001 -> sum=0x00000000, cout=1, ovf=0 (carry crosses all bytes).
//  3. sub 0x7F-0x7E -> 0x00000001 cout=1; sub 5-10 -> 0xFFFFFFFB cout=0;
//     sub 0x80000000-1 -> 0x7FFFFFFF ovf=1.
//  4. all four req_valid held high -> grants 0,1,2,3,0 in that order; rsp_id sequence matches.
//  5. rsp_ready low 10 cycles in RESP -> rsp_* stable, rsp_valid=1, req_ready all 0.
//  6. reset pulse during RUN idx=2 -> outputs at reset values immediately, no rsp for the aborted op.
//     The next grant goes to the lowest valid id starting from 0.

Source files
------------

// File: rtl/cla_mp_arbiter_pkg.sv
// Shared types for the multi-requester byte-serial carry-lookahead arbiter.
package cla_mp_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

endpackage

// File: rtl/cla_mp_arbiter_if.sv
// Request/response bundle between client datapaths and cla_mp_arbiter.
interface cla_mp_arbiter_if
    import cla_mp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORDS   = 4
);
    localparam int OW  = BYTE_W * WORDS;
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ*OW-1:0] req_x;
    logic [NUM_REQ*OW-1:0] req_y;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [OW-1:0]         rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovf;

    modport master (
        output req_valid, req_mode, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_mode, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/CarryLookAhead.sv
// 8-bit carry-lookahead adder; mode=1 inverts y, carry-in is supplied separately.
module CarryLookAhead (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       mode,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] yy;
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;

    assign yy = y ^ {8{mode}};
    assign g  = x & yy;
    assign p  = x ^ yy;

    // Each carry is the flat OR of generate terms gated by the propagate chain.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int unsigned j = i; j > 0; j--) begin
                acc = acc | (pp & g[j-1]);
                pp  = pp & p[j-1];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/cla_mp_arbiter.sv
// Round-robin arbiter sharing one 8-bit CLA; each granted add/sub runs LSB-first over WORDS bytes.
module cla_mp_arbiter
    import cla_mp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORDS   = 4
) (
    input logic             clk,
    input logic             reset,
    cla_mp_arbiter_if.slave bus
);
    localparam int OW  = BYTE_W * WORDS;
    localparam int IDW = $clog2(NUM_REQ);
    localparam int IXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t state;
    state_t nxt;

    logic [IDW-1:0]                ptr;
    logic [IDW-1:0]                gid;
    logic [WORDS-1:0][BYTE_W-1:0]  xr;
    logic [WORDS-1:0][BYTE_W-1:0]  yr;
    logic [WORDS-1:0][BYTE_W-1:0]  sum_r;
    logic                          carry;
    logic                          cout_r;
    logic                          ovf_r;
    logic [IXW-1:0]                idx;
    logic                          last;

    logic [NUM_REQ-1:0][OW-1:0]    xin;
    logic [NUM_REQ-1:0][OW-1:0]    yin;
    logic [IDW:0]                  pick;
    logic                          pick_ok;
    logic [IDW-1:0]                pick_id;
    logic                          accept;
    logic                          rsp_fire;

    logic [BYTE_W-1:0]             cla_sum;
    logic                          cla_cout;

    // First set bit at or above p, wrapping; MSB of the result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     p);
        logic [IDW:0] r;
        int unsigned  t;
        r = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            t = (32'(p) + k) % NUM_REQ;
            if (!r[IDW] && v[IDW'(t)]) begin
                r = {1'b1, IDW'(t)};
            end
        end
        return r;
    endfunction

    assign xin     = bus.req_x;
    assign yin     = bus.req_y;
    assign pick    = rr_pick(bus.req_valid, ptr);
    assign pick_ok = pick[IDW];
    assign pick_id = pick[IDW-1:0];
    assign last    = (idx == IXW'(WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // req_ready is gated by reset so a pending request is never strobed while held in reset.
    always_comb begin
        nxt           = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        rsp_fire      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_ok && !reset) begin
                    bus.req_ready[pick_id] = 1'b1;
                    accept                 = 1'b1;
                    nxt                    = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_fire = 1'b1;
                    nxt      = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            gid    <= '0;
            xr     <= '0;
            yr     <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else begin
            if (accept) begin
                xr    <= xin[pick_id];
                yr    <= yin[pick_id] ^ {OW{bus.req_mode[pick_id]}};
                carry <= bus.req_mode[pick_id];
                gid   <= pick_id;
                idx   <= '0;
            end
            if (state == RUN) begin
                sum_r[idx] <= cla_sum;
                carry      <= cla_cout;
                idx        <= idx + 1'b1;
                if (last) begin
                    cout_r <= cla_cout;
                    ovf_r  <= (xr[WORDS-1][BYTE_W-1] == yr[WORDS-1][BYTE_W-1]) &&
                              (cla_sum[BYTE_W-1] != xr[WORDS-1][BYTE_W-1]);
                end
            end
            if (rsp_fire) begin
                ptr <= IDW'((32'(gid) + 1) % NUM_REQ);
            end
        end
    end

    // y is already conditioned, so the adder always runs in add mode.
    CarryLookAhead u_cla (
        .x    (xr[idx]),
        .y    (yr[idx]),
        .mode (1'b0),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = gid;
    assign bus.rsp_sum   = sum_r;
    assign bus.rsp_cout  = cout_r;
    assign bus.rsp_ovf   = ovf_r;

endmodule

// File: tb/tb_cla_mp_arbiter.sv
// Randomized self-checking bench for cla_mp_arbiter against a word-level arithmetic model.
module tb_cla_mp_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;

    logic clk;
    logic reset;

    cla_mp_arbiter_if #(.NUM_REQ(N), .WORDS(W)) bus ();

    cla_mp_arbiter #(.NUM_REQ(N), .WORDS(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        v  [N];
    logic        md [N];
    logic [31:0] xs [N];
    logic [31:0] ys [N];

    assign bus.req_valid = {v[3], v[2], v[1], v[0]};
    assign bus.req_mode  = {md[3], md[2], md[1], md[0]};
    assign bus.req_x     = {xs[3], xs[2], xs[1], xs[0]};
    assign bus.req_y     = {ys[3], ys[2], ys[1], ys[0]};

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    // Signed overflow judged from the exact integer result, carry from unsigned magnitude.
    function automatic void model_op(input logic [31:0] x, input logic [31:0] y, input logic m,
                                     output logic [31:0] s, output logic c, output logic o);
        longint sx;
        longint sy;
        longint r;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        r  = m ? (sx - sy) : (sx + sy);
        s  = m ? (x - y) : (x + y);
        c  = m ? (ux >= uy) : ((ux + uy) > 64'hFFFF_FFFF);
        o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic load(input int i, input logic m, input logic [31:0] x, input logic [31:0] y);
        v[i]  = 1'b1;
        md[i] = m;
        xs[i] = x;
        ys[i] = y;
    endtask

    task automatic wait_grant(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        #1;
        while (!ok && n < 40) begin
            if (bus.req_ready != '0) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!ok) check("grant_timeout", 0, 1);
    endtask

    task automatic serve(input int hold, input int exp_id, input bit drop,
                         output logic [31:0] s, output logic c, output logic o);
        bit          ok;
        int          g;
        int          gd;
        int          lat;
        bit          busy_rdy;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        s = '0;
        c = 1'b0;
        o = 1'b0;
        wait_grant(ok);
        if (!ok) return;
        g  = model_pick();
        gd = -1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gd = i;
        check("ready_onehot", 32'($countones(bus.req_ready)), 1);
        check("grant", 32'(gd), 32'(g));
        if (exp_id >= 0) check("grant_seq", 32'(gd), 32'(exp_id));
        if (g < 0) g = 0;
        model_op(xs[g], ys[g], md[g], es, ec, eo);
        @(negedge clk);
        v[g] = 1'b0;
        lat  = 1;
        if (drop) begin
            for (int i = 0; i < N; i++) if (v[i] && $urandom_range(0, 7) == 0) v[i] = 1'b0;
        end
        busy_rdy = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.req_ready != '0) busy_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("busy_ready", 32'(busy_rdy), 0);
        check("latency", 32'(lat), 32'(W + 1));
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 32'(bus.rsp_valid), 1);
            check("rsp_sum", bus.rsp_sum, es);
            check("rsp_cout", 32'(bus.rsp_cout), 32'(ec));
            check("rsp_ovf", 32'(bus.rsp_ovf), 32'(eo));
            check("rsp_id", 32'(bus.rsp_id), 32'(g));
            check("resp_ready", 32'(bus.req_ready), 0);
            if (h < hold) @(negedge clk);
        end
        s = bus.rsp_sum;
        c = bus.rsp_cout;
        o = bus.rsp_ovf;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        ptr_m = (g + 1) % N;
        check("rsp_drop", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic        c;
        logic        o;
        bit          ok;

        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; md[i] = 1'b0; xs[i] = '0; ys[i] = '0;
        end
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        load(1, 1'b0, 32'h1234_5678, 32'h1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_valid", 32'(bus.rsp_valid), 0);
        check("rst_id",    32'(bus.rsp_id), 0);
        check("rst_sum",   bus.rsp_sum, 0);
        check("rst_cout",  32'(bus.rsp_cout), 0);
        check("rst_ovf",   32'(bus.rsp_ovf), 0);
        v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic, one requester at a time, walking the pointer to 0 again.
        load(0, 1'b0, 32'h0000_007F, 32'h0000_0001);
        serve(0, 0, 1'b0, s, c, o);
        check("t1_sum", s, 32'h0000_0080); check("t1_cout", 32'(c), 0); check("t1_ovf", 32'(o), 0);
        load(1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        serve(0, 1, 1'b0, s, c, o);
        check("t2_sum", s, 32'h0); check("t2_cout", 32'(c), 1); check("t2_ovf", 32'(o), 0);
        load(2, 1'b1, 32'h0000_007F, 32'h0000_007E);
        serve(0, 2, 1'b0, s, c, o);
        check("t3a_sum", s, 32'h1); check("t3a_cout", 32'(c), 1);
        load(3, 1'b1, 32'd5, 32'd10);
        serve(0, 3, 1'b0, s, c, o);
        check("t3b_sum", s, 32'hFFFF_FFFB); check("t3b_cout", 32'(c), 0);
        load(0, 1'b1, 32'h8000_0000, 32'h1);
        serve(0, 0, 1'b0, s, c, o);
        check("t3c_sum", s, 32'h7FFF_FFFF); check("t3c_ovf", 32'(o), 1);
        load(1, 1'b1, 32'hA5C3_0F96, 32'h0);
        serve(0, 1, 1'b0, s, c, o);
        check("ysub0_sum", s, 32'hA5C3_0F96); check("ysub0_cout", 32'(c), 1);
        load(2, 1'(($urandom) & 1), rand_word(), rand_word());
        serve(0, 2, 1'b0, s, c, o);
        load(3, 1'(($urandom) & 1), rand_word(), rand_word());
        serve(0, 3, 1'b0, s, c, o);

        // All requesters pending: strict rotation 0,1,2,3,0.
        for (int i = 0; i < N; i++) load(i, 1'(($urandom) & 1), rand_word(), rand_word());
        for (int k = 0; k < 5; k++) begin
            serve(0, k % N, 1'b0, s, c, o);
            load(k % N, 1'(($urandom) & 1), rand_word(), rand_word());
        end

        // Consumer stalls in RESP.
        serve(10, -1, 1'b0, s, c, o);
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        @(negedge clk);

        // Reset while byte 2 is in flight.
        load(2, 1'b0, 32'h0101_0101, 32'h0202_0202);
        wait_grant(ok);
        @(negedge clk);
        v[2] = 1'b0;
        repeat (2) @(negedge clk);
        load(1, 1'b0, 32'h0000_0010, 32'h0000_0020);
        load(3, 1'b1, 32'h0000_0030, 32'h0000_0001);
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(bus.rsp_valid), 0);
        check("abort_sum",   bus.rsp_sum, 0);
        check("abort_id",    32'(bus.rsp_id), 0);
        check("abort_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        serve(0, 1, 1'b0, s, c, o);
        check("after_abort_sum", s, 32'h0000_0030);

        // Random traffic with random stalls and early withdrawals.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1)
                    load(i, 1'(($urandom) & 1), rand_word(), rand_word());
            end
            if (!(v[0] || v[1] || v[2] || v[3]))
                load($urandom_range(0, N - 1), 1'(($urandom) & 1), rand_word(), rand_word());
            serve($urandom_range(0, 3), -1, 1'b1, s, c, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
